// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: owns the uPC, decodes the flow field of each
// micro-op and emits PC-increment, flag-update, retire and trap strobes.
module dzcpu_useq #(
  parameter int         UOP_W  = 13,
  parameter logic [4:0] JCB_OP = 5'd10
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMop,
  input  logic [7:0]       iLutIdx,
  input  logic [7:0]       iCbLutIdx,
  input  logic [UOP_W-1:0] iUop,
  input  logic             iZflag,
  input  logic             iStall,
  output logic [7:0]       oUopAddr,
  output logic             oUopValid,
  output logic             oPcInc,
  output logic             oFlagsUpdate,
  output logic             oCbPrefix,
  output logic             oRetired,
  output logic             oTrap,
  output logic [15:0]      oRetireCnt
);

  localparam logic [1:0] S_DISPATCH = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_TRAP     = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  upc_q, upc_d;
  logic        cb_q, cb_d;
  logic [15:0] cnt_q, cnt_d;

  logic        valid_c, pc_inc_c, fu_c, ret_c, adv_c;
  logic [3:0]  flow;
  logic        is_jcb;

  // The opcode byte and operand field are consumed by the LUTs and datapath.
  logic        unused_ok;
  assign unused_ok = ^{iMop, iUop[3:0]};

  assign flow   = iUop[12:9];
  assign is_jcb = (iUop[8:4] == JCB_OP);

  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    cb_d     = cb_q;
    cnt_d    = cnt_q;
    valid_c  = 1'b0;
    pc_inc_c = 1'b0;
    fu_c     = 1'b0;
    ret_c    = 1'b0;
    adv_c    = 1'b0;

    case (state_q)
      S_DISPATCH: begin
        upc_d   = iLutIdx;
        cb_d    = 1'b0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        valid_c = 1'b1;
        case (flow)
          4'd0, 4'd9: adv_c = 1'b1;
          4'd1: begin pc_inc_c = 1'b1; adv_c = 1'b1; end
          4'd2: ret_c = 1'b1;
          4'd3: begin pc_inc_c = 1'b1; ret_c = 1'b1; end
          4'd4: begin fu_c = 1'b1; ret_c = 1'b1; end
          4'd5: begin pc_inc_c = 1'b1; fu_c = 1'b1; ret_c = 1'b1; end
          4'd6: begin pc_inc_c = 1'b1; ret_c = iZflag;  adv_c = ~iZflag; end
          4'd7: begin pc_inc_c = 1'b1; ret_c = ~iZflag; adv_c = iZflag;  end
          4'd8: begin fu_c = 1'b1; adv_c = 1'b1; end
          default: begin
            valid_c = 1'b0;
            state_d = S_TRAP;
          end
        endcase

        if (ret_c) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = S_DISPATCH;
        end else if (adv_c) begin
          if (is_jcb) begin
            upc_d = iCbLutIdx;
            cb_d  = 1'b1;
          end else if (upc_q == 8'hFF) begin
            // uPC never wraps to 0; running off the ROM end is fatal.
            state_d = S_TRAP;
          end else begin
            upc_d = upc_q + 8'd1;
          end
        end
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase

    if (iStall) begin
      state_d  = state_q;
      upc_d    = upc_q;
      cb_d     = cb_q;
      cnt_d    = cnt_q;
      valid_c  = 1'b0;
      pc_inc_c = 1'b0;
      fu_c     = 1'b0;
      ret_c    = 1'b0;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_DISPATCH;
      upc_q   <= 8'd0;
      cb_q    <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cb_q    <= cb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oUopAddr     = upc_q;
  assign oUopValid    = valid_c;
  assign oPcInc       = pc_inc_c;
  assign oFlagsUpdate = fu_c;
  assign oRetired     = ret_c;
  assign oCbPrefix    = cb_q;
  assign oTrap        = (state_q == S_TRAP);
  assign oRetireCnt   = cnt_q;

endmodule

// File: doc/dzcpu_useq.md
# dzcpu_useq

Microcode sequencer for the dzcpu core. It owns the micro-program counter (uPC) that addresses `dzcpu_ucode_rom` and consumes the flow-control field of each returned micro-op. It dispatches opcodes through `dzcpu_ucode_lut` and the 0xCB-prefix table `dzcpu_ucode_cblut`, and emits PC-increment, flag-update, retire and trap strobes to the datapath. It sits between the fetch path (opcode byte on the memory data bus) and the datapath that executes the micro-op's op/operand fields.

## Interface
Parameters:
- `UOP_W`, 13: micro-op width. Flow field `[12:9]`, op field `[8:4]`, operand field `[3:0]`.
- `JCB_OP`, 5'd10: op-field code of the `jcb` (jump to CB table) micro-op.

Ports:
- `iClock`  in  1  core clock; all state updates on the rising edge.
- `iReset`  in  1  asynchronous, active-low reset.
- `iMop`  in  8  opcode byte currently on the memory data bus.
- `iLutIdx`  in  8  flow index from `dzcpu_ucode_lut` for `iMop`.
- `iCbLutIdx`  in  8  flow index from `dzcpu_ucode_cblut` for `iMop`.
- `iUop`  in  UOP_W  micro-op returned combinationally by the ROM for `oUopAddr`.
- `iZflag`  in  1  current Z flag.
- `iStall`  in  1  memory wait; freezes the sequencer.
- `oUopAddr`  out  8  ROM address (registered uPC).
- `oUopValid`  out  1  datapath executes `iUop` this cycle.
- `oPcInc`  out  1  increment the architectural PC this cycle.
- `oFlagsUpdate`  out  1  latch ALU flags this cycle.
- `oCbPrefix`  out  1  current instruction is CB-prefixed.
- `oRetired`  out  1  one-cycle pulse on the last micro-op of an instruction.
- `oTrap`  out  1  sticky; an illegal flow code was seen or uPC would wrap.
- `oRetireCnt`  out  16  retired-instruction counter; wraps at 0xFFFF to 0.

## Operation
- States: DISPATCH, EXEC, TRAP.
- DISPATCH:
  - `oUopValid` = 0.
  - Unless stalled, uPC ← `iLutIdx`, `oCbPrefix` ← 0, then go to EXEC.
  - Index 0 is valid: the generic single-byte flow.
- EXEC:
  - `oUopValid` = 1 and `oUopAddr` = uPC.
  - Decode `flow = iUop[12:9]`:
    - 0 op / 9 nop: uPC+1.
    - 1 inc: `oPcInc`, uPC+1.
    - 2 eof: retire.
    - 3 inc_eof: `oPcInc`, retire.
    - 4 eof_fu: `oFlagsUpdate`, retire.
    - 5 inc_eof_fu: `oPcInc`, `oFlagsUpdate`, retire.
    - 6 inc_eof_z: `oPcInc`. If `iZflag`=1, retire; otherwise uPC+1.
    - 7 inc_eof_nz: `oPcInc`. If `iZflag`=0, retire; otherwise uPC+1.
    - 8 update_flags: `oFlagsUpdate`, uPC+1.
    - 10–15: go to TRAP. No strobes are emitted.
  - Retire means: `oRetired` pulse, `oRetireCnt`+1, go to DISPATCH.
- `jcb`: if `iUop[8:4]`==`JCB_OP` and the flow does not retire, uPC ← `iCbLutIdx` instead of uPC+1, and `oCbPrefix` ← 1. The flow's `oPcInc` still applies.
- uPC wrap: if uPC is 255 and the next uPC would be 256, go to TRAP. uPC never wraps to 0.
- TRAP: all strobes 0, `oUopValid` = 0, `oTrap` = 1. It is left only by reset.
- `iStall`=1 (in any state):
  - All state, uPC and counters hold.
  - `oPcInc`, `oFlagsUpdate`, `oRetired` and `oUopValid` are forced to 0.
  - `oUopAddr` holds.
- Reset values:
  - state DISPATCH, uPC 0.
  - All strobes 0.
  - `oCbPrefix` 0, `oTrap` 0, `oRetireCnt` 0.

## Timing
- Strobes (`oPcInc`, `oFlagsUpdate`, `oRetired`, `oUopValid`) are combinational from state and `iUop` and are valid in the same cycle as the micro-op.
- DISPATCH costs 1 cycle. An instruction of N micro-ops occupies N+1 cycles.
- Back-to-back instructions: DISPATCH follows the retiring EXEC cycle directly, with no bubble beyond DISPATCH.
- `iZflag` is sampled in the same cycle as the conditional micro-op.
- Reset is asynchronous: it takes effect immediately, even mid-instruction. No partial retire is counted.
- `iMop` must be stable during the DISPATCH cycle and during any `jcb` cycle.

## Test plan
- Reset with `iReset`=0 mid-EXEC at uPC 20 -> outputs go to reset values immediately. After release, first DISPATCH loads `iLutIdx`.
- Single-byte op: `iLutIdx`=0, ROM[0] flow 3 -> DISPATCH, then 1 EXEC cycle with `oPcInc`=1 and `oRetired`=1. `oRetireCnt` 0→1.
- LDSPnn: `iLutIdx`=1, flows 1,1,0,3 at uPC 1–4 -> 5 cycles total, `oPcInc` asserted 3 times, retire at uPC 4.
- JRNZ: idx 17, flows 1,0,6. With `iZflag`=1 -> retire at uPC 19. With `iZflag`=0 -> continue to uPC 22 and retire on its eof.
- CB prefix: idx 13, flows 1,0,1+`jcb` at uPC 15, `iCbLutIdx`=16 -> uPC 16 with `oCbPrefix`=1. Flow 4 at 16 -> `oFlagsUpdate` and retire.
- Trap and stall: flow 12 at any uPC -> TRAP and `oTrap` sticky. uPC at 255 with flow 0 -> TRAP. `iStall`=1 for 3 cycles mid-LDSPnn -> uPC holds and strobes are 0. Resuming gives an identical remaining sequence.
